exp_lut_prog: RTL

//  Programmable 128x32 coefficient table for the exp unit: the write-side counterpart of the fixed exp LUT.

---
 rtl/exp_lut_prog_if.sv | 41 ++++
 rtl/exp_lut_prog.sv | 111 +++++++++++
 2 files changed

// File: rtl/exp_lut_prog_if.sv
// Bulk-load and read port bundle for the programmable exp coefficient table.
// EXP_LUT_PARITY_EN adds the parity test hook and read parity error flag.
interface exp_lut_prog_if #(
    parameter int unsigned AddrW = 7,
    parameter int unsigned DataW = 32
) ();
    logic              load_start;
    logic [AddrW-1:0]  load_base;
    logic [AddrW:0]    load_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DataW-1:0]  wr_data;
    logic              busy;
    logic              load_done;
    logic              rd_en;
    logic [AddrW-1:0]  rd_addr;
    logic              rd_valid;
    logic [DataW-1:0]  rd_data;
`ifdef EXP_LUT_PARITY_EN
    logic              inj_parity_err;
    logic              rd_parity_err;
`endif

    modport master (
        output load_start, load_base, load_len, wr_valid, wr_data, rd_en, rd_addr,
`ifdef EXP_LUT_PARITY_EN
        output inj_parity_err,
        input  rd_parity_err,
`endif
        input  wr_ready, busy, load_done, rd_valid, rd_data
    );

    modport slave (
        input  load_start, load_base, load_len, wr_valid, wr_data, rd_en, rd_addr,
`ifdef EXP_LUT_PARITY_EN
        input  inj_parity_err,
        output rd_parity_err,
`endif
        output wr_ready, busy, load_done, rd_valid, rd_data
    );
endinterface

// File: rtl/exp_lut_prog.sv
// Programmable 128x32 exp coefficient table: valid/ready bulk loader plus 1-cycle registered read.
// EXP_LUT_PARITY_EN adds a stored even-parity bit per entry and a read parity error flag.
module exp_lut_prog #(
    parameter int unsigned AddrW = 7,
    parameter int unsigned DataW = 32
) (
    input logic           clk_i,
    input logic           reset_ni,
    exp_lut_prog_if.slave lut_if
);
    localparam int unsigned Depth = 2 ** AddrW;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] ptr_q, ptr_d;
    logic [AddrW:0]   remaining_q, remaining_d;
    logic             rd_valid_q;
    logic [DataW-1:0] rd_data_q, rd_data_d;
    logic             wr_fire;
    logic             bypass;

    // Storage is deliberately not reset so the table survives a reset.
    logic [DataW-1:0] mem_q [Depth];

    assign wr_fire = lut_if.wr_valid && (state_q == StLoad);
    assign bypass  = wr_fire && (lut_if.rd_addr == ptr_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (lut_if.load_start) begin
                    state_d     = StLoad;
                    ptr_d       = lut_if.load_base;
                    remaining_d = (lut_if.load_len == '0) ? (AddrW+1)'(Depth) : lut_if.load_len;
                end
            end
            StLoad: begin
                if (wr_fire) begin
                    ptr_d       = ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (AddrW+1)'(1)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[ptr_q] <= lut_if.wr_data;
    end

    // Write-first: a read hitting the entry being written returns the new word.
    assign rd_data_d = bypass ? lut_if.wr_data : mem_q[lut_if.rd_addr];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= lut_if.rd_en;
            if (lut_if.rd_en) rd_data_q <= rd_data_d;
        end
    end

`ifdef EXP_LUT_PARITY_EN
    logic             par_mem_q [Depth];
    logic             wr_par;
    logic             rd_par_err_q, rd_par_err_d;

    assign wr_par       = (^lut_if.wr_data) ^ lut_if.inj_parity_err;
    assign rd_par_err_d = bypass ? lut_if.inj_parity_err
                                 : (par_mem_q[lut_if.rd_addr] != (^mem_q[lut_if.rd_addr]));

    always_ff @(posedge clk_i) begin
        if (wr_fire) par_mem_q[ptr_q] <= wr_par;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_par_err_q <= 1'b0;
        end else if (lut_if.rd_en) begin
            rd_par_err_q <= rd_par_err_d;
        end
    end

    assign lut_if.rd_parity_err = rd_par_err_q;
`endif

    assign lut_if.wr_ready  = (state_q == StLoad);
    assign lut_if.busy      = (state_q == StLoad) || (state_q == StDone);
    assign lut_if.load_done = (state_q == StDone);
    assign lut_if.rd_valid  = rd_valid_q;
    assign lut_if.rd_data   = rd_data_q;
endmodule
